// File: rtl/dot_stream_pkg.sv
// Shared types, default widths and helpers for the streaming dot-product engine.
// Optional feature macro: DOT_SATURATE_EN (saturating accumulator).
package dot_stream_pkg;

    localparam int unsigned DEF_ELEMENT_WIDTH = 32;
    localparam int unsigned DEF_NO_OF_UNITS   = 8;
    localparam int unsigned PROD_W            = 2 * DEF_ELEMENT_WIDTH;
    localparam int unsigned SUM_W             = PROD_W + $clog2(DEF_NO_OF_UNITS);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    // Widened by one bit so totals near 2^32 cannot overflow the round-up.
    function automatic logic [31:0] beat_count(input logic [31:0] total,
                                               input int unsigned lanes);
        logic [32:0] t;
        t = {1'b0, total} + 33'(lanes) - 33'd1;
        return 32'(t / 33'(lanes));
    endfunction

endpackage

// File: rtl/dot_lane_adder_tree.sv
// Combinational balanced adder tree reducing NO_OF_UNITS signed lane terms to one sum.
// Optional feature macro: none (DOT_SATURATE_EN is handled in the top).
module dot_lane_adder_tree
    import dot_stream_pkg::*;
#(
    parameter int unsigned NO_OF_UNITS = DEF_NO_OF_UNITS,
    parameter int unsigned IN_WIDTH    = PROD_W,
    parameter int unsigned OUT_WIDTH   = SUM_W
) (
    input  logic        [NO_OF_UNITS*IN_WIDTH-1:0] terms,
    output logic signed [OUT_WIDTH-1:0]            sum
);

    localparam int unsigned LEVELS = $clog2(NO_OF_UNITS);
    localparam int unsigned LEAVES = 1 << LEVELS;
    localparam int unsigned NODES  = 2 * LEAVES - 1;

    // Heap layout: node k has children 2k+1 and 2k+2, leaves start at LEAVES-1.
    logic signed [OUT_WIDTH-1:0] node [NODES];
    logic signed [IN_WIDTH-1:0]  term;

    always_comb begin
        term = '0;
        for (int k = 0; k < int'(NODES); k++) begin
            node[k] = '0;
        end
        for (int i = 0; i < int'(NO_OF_UNITS); i++) begin
            term = terms[i*IN_WIDTH +: IN_WIDTH];
            node[int'(LEAVES) - 1 + i] = OUT_WIDTH'(term);
        end
        for (int k = int'(LEAVES) - 2; k >= 0; k--) begin
            node[k] = node[2*k+1] + node[2*k+2];
        end
        sum = node[0];
    end

endmodule

// File: rtl/vector_dot_stream_ctrl.sv
// Streaming length-programmable dot product: 3-stage product/tree/accumulate pipe.
// Optional feature macro: DOT_SATURATE_EN (saturating accumulate with sticky flag).
module vector_dot_stream_ctrl
    import dot_stream_pkg::*;
#(
    parameter int unsigned ELEMENT_WIDTH = DEF_ELEMENT_WIDTH,
    parameter int unsigned NO_OF_UNITS   = DEF_NO_OF_UNITS,
    parameter int unsigned ACC_WIDTH     = 2 * ELEMENT_WIDTH + 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [31:0]                          total,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] vec_a,
    input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] vec_b,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [ACC_WIDTH-1:0]                 dot_out,
    output logic                                 busy,
    output logic                                 finish
);

    localparam int unsigned PROD_WIDTH = 2 * ELEMENT_WIDTH;
    localparam int unsigned SUM_WIDTH  = PROD_WIDTH + $clog2(NO_OF_UNITS);
    localparam int unsigned LANE_W     = $clog2(NO_OF_UNITS + 1);
    localparam logic [31:0] UNITS32    = 32'(NO_OF_UNITS);

    state_e state_q, state_d;

    logic [31:0]                        beats_q, beat_cnt_q;
    logic [LANE_W-1:0]                  last_lanes_q;
    logic                               s1_valid_q, s2_valid_q, s3_valid_q;
    logic [NO_OF_UNITS*PROD_WIDTH-1:0]  prod_d, prod_q;
    logic signed [SUM_WIDTH-1:0]        tree_sum, sum_q;
    logic signed [ACC_WIDTH-1:0]        acc_q, acc_d, result;
    logic [ACC_WIDTH-1:0]               dot_q;
    logic                               finish_q;
    logic                               beat_accept, final_beat, pipe_empty, start_accept;
    logic [31:0]                        tail_rem;

    assign in_ready     = (state_q == StRun);
    assign out_valid    = (state_q == StDone);
    assign busy         = (state_q != StIdle);
    assign finish       = finish_q;
    assign dot_out      = dot_q;
    assign beat_accept  = in_valid && in_ready;
    assign final_beat   = (beat_cnt_q == beats_q - 32'd1);
    assign pipe_empty   = !(s1_valid_q || s2_valid_q || s3_valid_q);
    assign start_accept = (state_q == StIdle) && start;
    assign tail_rem     = total % UNITS32;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = (total != 32'd0) ? StRun : StDone;
            StRun:   if (beat_accept && final_beat) state_d = StDrain;
            StDrain: if (pipe_empty) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Lanes past the element count on the final beat contribute zero.
    always_comb begin
        prod_d = '0;
        for (int i = 0; i < int'(NO_OF_UNITS); i++) begin
            if (!(final_beat && (LANE_W'(i) >= last_lanes_q))) begin
                prod_d[i*PROD_WIDTH +: PROD_WIDTH] =
                    PROD_WIDTH'(signed'(vec_a[i*ELEMENT_WIDTH +: ELEMENT_WIDTH])) *
                    PROD_WIDTH'(signed'(vec_b[i*ELEMENT_WIDTH +: ELEMENT_WIDTH]));
            end
        end
    end

    dot_lane_adder_tree #(
        .NO_OF_UNITS (NO_OF_UNITS),
        .IN_WIDTH    (PROD_WIDTH),
        .OUT_WIDTH   (SUM_WIDTH)
    ) u_tree (
        .terms (prod_q),
        .sum   (tree_sum)
    );

`ifdef DOT_SATURATE_EN
    localparam int unsigned WIDE_W = ((ACC_WIDTH > SUM_WIDTH) ? ACC_WIDTH : SUM_WIDTH) + 1;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic signed [WIDE_W-1:0]     acc_wide;
    logic [WIDE_W-ACC_WIDTH:0]    acc_top;
    logic                         acc_ovf, sat_q, sat_neg_q;

    always_comb begin
        acc_wide = WIDE_W'(acc_q) + WIDE_W'(sum_q);
        acc_top  = acc_wide[WIDE_W-1:ACC_WIDTH-1];
        acc_ovf  = !((&acc_top) || !(|acc_top));
        acc_d    = acc_ovf ? (acc_wide[WIDE_W-1] ? ACC_MIN : ACC_MAX)
                           : acc_wide[ACC_WIDTH-1:0];
        result   = sat_q ? (sat_neg_q ? ACC_MIN : ACC_MAX) : acc_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_q     <= 1'b0;
            sat_neg_q <= 1'b0;
        end else if (start_accept) begin
            sat_q     <= 1'b0;
            sat_neg_q <= 1'b0;
        end else if (s2_valid_q && acc_ovf) begin
            sat_q     <= 1'b1;
            sat_neg_q <= acc_wide[WIDE_W-1];
        end
    end
`else
    always_comb begin
        acc_d  = acc_q + ACC_WIDTH'(sum_q);
        result = acc_q;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beats_q      <= '0;
            beat_cnt_q   <= '0;
            last_lanes_q <= '0;
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            s3_valid_q   <= 1'b0;
            prod_q       <= '0;
            sum_q        <= '0;
            acc_q        <= '0;
            dot_q        <= '0;
            finish_q     <= 1'b0;
        end else begin
            finish_q   <= out_valid && out_ready;
            s1_valid_q <= beat_accept;
            s2_valid_q <= s1_valid_q;
            s3_valid_q <= s2_valid_q;
            if (beat_accept) begin
                prod_q     <= prod_d;
                beat_cnt_q <= beat_cnt_q + 32'd1;
            end
            if (s1_valid_q) sum_q <= tree_sum;
            if (s2_valid_q) acc_q <= acc_d;
            if (start_accept) begin
                beats_q      <= beat_count(total, NO_OF_UNITS);
                beat_cnt_q   <= '0;
                last_lanes_q <= (tail_rem == 32'd0) ? LANE_W'(NO_OF_UNITS) : LANE_W'(tail_rem);
                acc_q        <= '0;
                if (total == 32'd0) dot_q <= '0;
            end
            if (state_q == StDrain && pipe_empty) dot_q <= result;
        end
    end

endmodule

// File: tb/tb_vector_dot_stream_ctrl.sv
// Randomised self-checking bench: default instance plus a 40-bit accumulator instance.
// Expected values come from an exact-arithmetic model over the element lists.
module tb_vector_dot_stream_ctrl;

    localparam int unsigned EW = 32;
    localparam int unsigned N  = 8;

    logic           clk = 1'b0;
    logic           reset, start, in_valid, out_ready;
    logic [31:0]    total;
    logic [EW*N-1:0] vec_a, vec_b;
    logic           in_ready, out_valid, busy, finish;
    logic [79:0]    dot_out;
    logic           in_ready_w, out_valid_w, busy_w, finish_w;
    logic [39:0]    dot_out_w;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [31:0] a_el [$];
    logic [31:0] b_el [$];

    always #5 clk = ~clk;

    vector_dot_stream_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .total     (total),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .vec_a     (vec_a),
        .vec_b     (vec_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dot_out   (dot_out),
        .busy      (busy),
        .finish    (finish)
    );

    vector_dot_stream_ctrl #(
        .ELEMENT_WIDTH (32),
        .NO_OF_UNITS   (8),
        .ACC_WIDTH     (40)
    ) dut_w (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .total     (total),
        .in_valid  (in_valid),
        .in_ready  (in_ready_w),
        .vec_a     (vec_a),
        .vec_b     (vec_b),
        .out_valid (out_valid_w),
        .out_ready (out_ready),
        .dot_out   (dot_out_w),
        .busy      (busy_w),
        .finish    (finish_w)
    );

    task automatic check_eq(input string tag, input logic [127:0] got,
                            input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Exact dot product over the first tot elements, reduced to a width-bit result.
    function automatic logic [127:0] model_dot(input int unsigned tot, input int unsigned width);
        logic signed [127:0] acc, bsum, pa, pb, maxv, minv;
        bit sat, neg;
        int unsigned nb;
        acc  = 0;
        sat  = 0;
        neg  = 0;
        maxv = (128'sd1 <<< (width - 1)) - 128'sd1;
        minv = -(128'sd1 <<< (width - 1));
        nb   = (tot + N - 1) / N;
        for (int unsigned bt = 0; bt < nb; bt++) begin
            bsum = 0;
            for (int unsigned i = 0; i < N; i++) begin
                if (bt * N + i < tot) begin
                    pa   = signed'(a_el[bt*N+i]);
                    pb   = signed'(b_el[bt*N+i]);
                    bsum = bsum + pa * pb;
                end
            end
            acc = acc + bsum;
`ifdef DOT_SATURATE_EN
            if (acc > maxv) begin
                acc = maxv; sat = 1; neg = 0;
            end else if (acc < minv) begin
                acc = minv; sat = 1; neg = 1;
            end
`endif
        end
        if (sat) acc = neg ? minv : maxv;
        return acc & ((128'd1 << width) - 128'd1);
    endfunction

    // mode: 0 random, 1 a=lane+1 b=1, 2 a=2 b=3, 3 a=-1 b=5, 4 max-positive
    task automatic fill(input int unsigned tot, input int mode);
        int unsigned nb;
        a_el.delete();
        b_el.delete();
        nb = (tot + N - 1) / N;
        for (int unsigned idx = 0; idx < nb * N; idx++) begin
            if (idx >= tot || mode == 0) begin
                a_el.push_back($urandom);
                b_el.push_back($urandom);
            end else if (mode == 1) begin
                a_el.push_back(32'((idx % N) + 1));
                b_el.push_back(32'd1);
            end else if (mode == 2) begin
                a_el.push_back(32'd2);
                b_el.push_back(32'd3);
            end else if (mode == 3) begin
                a_el.push_back(32'hFFFF_FFFF);
                b_el.push_back(32'd5);
            end else begin
                a_el.push_back(32'h7FFF_FFFF);
                b_el.push_back(32'h7FFF_FFFF);
            end
        end
    endtask

    // Returns at the negedge right after the beat's acceptance edge.
    task automatic feed_beat(input int unsigned bt, input int gap_mode);
        int cnt;
        int gaps;
        gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
        for (int g = 0; g < gaps; g++) begin
            in_valid = 1'b0;
            start    = 1'($urandom);
            for (int i = 0; i < int'(N); i++) begin
                vec_a[i*EW +: EW] = $urandom;
                vec_b[i*EW +: EW] = $urandom;
            end
            @(negedge clk);
        end
        start    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < int'(N); i++) begin
            vec_a[i*EW +: EW] = a_el[bt*N+i];
            vec_b[i*EW +: EW] = b_el[bt*N+i];
        end
        cnt = 0;
        while (!in_ready && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 20) check_eq("in_ready_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_case(input string name, input int unsigned tot, input int mode,
                            input int gap_mode, input int unsigned hold);
        logic [127:0] exp, exp_w;
        logic [79:0]  first_dot;
        int unsigned  nb, lat;
        fill(tot, mode);
        exp   = model_dot(tot, 80);
        exp_w = model_dot(tot, 40);
        nb    = (tot + N - 1) / N;
        start = 1'b1;
        total = tot;
        @(negedge clk);
        start = 1'b0;
        total = $urandom;
        check_eq({name, "_busy"}, busy, 1);
        if (tot == 0) begin
            check_eq({name, "_no_in_ready"}, in_ready, 0);
            check_eq({name, "_valid_now"}, out_valid, 1);
        end else begin
            for (int unsigned bt = 0; bt < nb; bt++) feed_beat(bt, gap_mode);
            check_eq({name, "_in_ready_drop"}, {in_ready, in_ready_w}, 0);
            lat = 0;
            while (!out_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            check_eq({name, "_latency"}, lat, 4);
        end
        first_dot = dot_out;
        repeat (hold) @(negedge clk);
        check_eq({name, "_hold_valid"}, {out_valid, out_valid_w, finish}, 3'b110);
        check_eq({name, "_stable"}, dot_out, first_dot);
        check_eq({name, "_dot"}, dot_out, exp);
        check_eq({name, "_dot_w"}, dot_out_w, exp_w);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({name, "_handshake"}, {finish, finish_w, out_valid, busy, busy_w}, 5'b11000);
        @(negedge clk);
        check_eq({name, "_finish_pulse"}, {finish, finish_w}, 0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        total     = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        vec_a     = '0;
        vec_b     = '0;
        repeat (2) @(negedge clk);
        check_eq("reset_state", {in_ready, out_valid, busy, finish, dot_out}, 0);
        reset = 1'b0;
        @(negedge clk);

        run_case("t1", 8, 1, 0, 0);
        run_case("t2", 13, 2, 0, 0);
        run_case("t3", 0, 0, 0, 0);
        run_case("t4", 24, 3, 1, 5);

        // Abandon a 4-beat job after two beats with an asynchronous reset.
        fill(32, 0);
        start = 1'b1;
        total = 32;
        @(negedge clk);
        start = 1'b0;
        feed_beat(0, 0);
        feed_beat(1, 0);
        in_valid = 1'b1;
        #2 reset = 1'b1;
        #1 check_eq("t5_async_reset", {in_ready, out_valid, busy, finish, dot_out}, 0);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        check_eq("t5_idle_after", {busy, out_valid, finish}, 0);
        run_case("t5_restart", 8, 0, 0, 0);

        run_case("t6_maxpos", 512, 4, 0, 0);

        for (int r = 0; r < 10; r++) begin
            run_case($sformatf("rand%0d", r), $urandom_range(1, 40), 0, 2,
                     $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
